// File: rtl/reg_read_arbiter.sv
// reg_read_arbiter: grants one of four requesters access to a shared 4:1
// register read path and returns the selected value with a valid/ack handshake.
// Optional build macro RD_ARB_RR_EN selects round-robin arbitration. Without it,
// fixed priority is used, with req[0] highest.
module reg_read_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        req,
    input  logic [7:0]        rd_sel,
    input  logic [DATA_W-1:0] q1,
    input  logic [DATA_W-1:0] q2,
    input  logic [DATA_W-1:0] q3,
    input  logic [DATA_W-1:0] q4,
    input  logic              ack,
    output logic [1:0]        mux_sel,
    output logic [3:0]        gnt,
    output logic [DATA_W-1:0] regData,
    output logic              valid,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        gnt_q, gnt_d;
    logic [1:0]        mux_sel_q, mux_sel_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic [1:0]        win;
    logic [DATA_W-1:0] rd_mux;

`ifdef RD_ARB_RR_EN
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] req_rot;
    logic [1:0] off;
    logic [1:0] gidx;

    // Rotate requests so the search starts at the pointer, then take the first hit
    always_comb begin
        req_rot = '0;
        for (int i = 0; i < 4; i++) begin
            req_rot[i] = req[ptr_q + 2'(i)];
        end
        if (req_rot[0])      off = 2'd0;
        else if (req_rot[1]) off = 2'd1;
        else if (req_rot[2]) off = 2'd2;
        else                 off = 2'd3;
        win = ptr_q + off;
    end

    // Index of the current grant, used to advance the pointer past the winner
    always_comb begin
        case (gnt_q)
            4'b0010: gidx = 2'd1;
            4'b0100: gidx = 2'd2;
            4'b1000: gidx = 2'd3;
            default: gidx = 2'd0;
        endcase
        ptr_d = ptr_q;
        if (state_q == RESP && ack) ptr_d = gidx + 2'd1;
    end

    // Round-robin pointer register
    always_ff @(posedge clk) begin
        if (reset) ptr_q <= 2'd0;
        else       ptr_q <= ptr_d;
    end
`else
    // Fixed priority: lowest requester index wins
    always_comb begin
        if (req[0])      win = 2'd0;
        else if (req[1]) win = 2'd1;
        else if (req[2]) win = 2'd2;
        else             win = 2'd3;
    end
`endif

    // Shared 4:1 read mux driven by the registered select
    always_comb begin
        case (mux_sel_q)
            2'd0:    rd_mux = q1;
            2'd1:    rd_mux = q2;
            2'd2:    rd_mux = q3;
            default: rd_mux = q4;
        endcase
    end

    // Next-state and output logic; everything holds unless a transition says otherwise
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        mux_sel_d = mux_sel_q;
        data_d    = data_q;
        valid_d   = valid_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d     = 4'b0001 << win;
                    mux_sel_d = rd_sel[{win, 1'b0} +: 2];
                    state_d   = SEL;
                end
            end
            SEL: begin
                // Capture exactly once; later changes on q* are not reflected
                data_d  = rd_mux;
                valid_d = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (ack) begin
                    valid_d   = 1'b0;
                    gnt_d     = '0;
                    mux_sel_d = '0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                gnt_d     = '0;
                mux_sel_d = '0;
                valid_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            mux_sel_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            mux_sel_q <= mux_sel_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
        end
    end

    assign mux_sel = mux_sel_q;
    assign gnt     = gnt_q;
    assign regData = data_q;
    assign valid   = valid_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_reg_read_arbiter.sv
// Bench for reg_read_arbiter: directed scenarios plus a randomized run, all
// compared cycle by cycle against a transaction-level reference model.
module tb_reg_read_arbiter;

    localparam int DW = 32;
`ifdef RD_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, ack;
    logic [3:0]    req;
    logic [7:0]    rd_sel;
    logic [DW-1:0] q1, q2, q3, q4;
    logic [1:0]    mux_sel;
    logic [3:0]    gnt;
    logic [DW-1:0] regData;
    logic          valid, busy;

    reg_read_arbiter #(.DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .req(req), .rd_sel(rd_sel),
        .q1(q1), .q2(q2), .q3(q3), .q4(q4), .ack(ack),
        .mux_sel(mux_sel), .gnt(gnt), .regData(regData),
        .valid(valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: a transaction is "age" edges old (0 = none in flight)
    int            m_age = 0;
    int            m_ptr = 0;
    int            m_w = 0;
    logic [3:0]    m_gnt = '0;
    logic [1:0]    m_mux = '0;
    logic [DW-1:0] m_data = '0;
    logic          m_valid = 1'b0;

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [DW-1:0] qv [4];
        @(posedge clk);
        qv = '{q1, q2, q3, q4};
        if (reset) begin
            m_age = 0; m_ptr = 0; m_gnt = '0; m_mux = '0; m_data = '0; m_valid = 1'b0;
        end else if (m_age == 0) begin
            if (req != 4'b0) begin
                m_w   = pick(req, RR ? m_ptr : 0);
                m_gnt = 4'(1 << m_w);
                m_mux = rd_sel[2*m_w +: 2];
                m_age = 1;
            end
        end else if (m_age == 1) begin
            m_data  = qv[m_mux];
            m_valid = 1'b1;
            m_age   = 2;
        end else if (ack) begin
            m_valid = 1'b0; m_gnt = '0; m_mux = '0;
            m_ptr   = (m_w + 1) % 4;
            m_age   = 0;
        end
        #1;
        chk("gnt", 64'(gnt), 64'(m_gnt));
        chk("mux_sel", 64'(mux_sel), 64'(m_mux));
        chk("regData", 64'(regData), 64'(m_data));
        chk("valid", 64'(valid), 64'(m_valid));
        chk("busy", 64'(busy), 64'(m_age != 0));
    endtask

    initial begin
        reset = 1'b1; ack = 1'b0; req = '0; rd_sel = '0;
        q1 = 1; q2 = 2; q3 = 3; q4 = 4;
        #1;
        step(); step();
        chk("rst_gnt", 64'(gnt), 0);
        chk("rst_valid", 64'(valid), 0);
        chk("rst_data", 64'(regData), 0);
        chk("rst_busy", 64'(busy), 0);
        reset = 1'b0;
        step();
        chk("idle_gnt", 64'(gnt), 0);

        // All four requesting, ack held high: fairness order (or fixed winner)
        req = 4'hf; rd_sel = 8'b11_10_01_00; ack = 1'b1;
        for (int t = 0; t < 5; t++) begin
            step();
            chk("multi_gnt", 64'(gnt), 64'(1 << (RR ? t % 4 : 0)));
            step();
            chk("multi_data", 64'(regData), 64'((RR ? t % 4 : 0) + 1));
            chk("multi_valid", 64'(valid), 1);
            step();
            chk("multi_idle_gnt", 64'(gnt), 0);
        end
        req = '0; ack = 1'b0;
        reset = 1'b1; step(); reset = 1'b0;

        // Basic read of q3 by requester 0
        req = 4'b0001; rd_sel = 8'b00_00_00_10;
        step();
        chk("basic_gnt", 64'(gnt), 64'h1);
        chk("basic_mux", 64'(mux_sel), 64'h2);
        chk("basic_valid0", 64'(valid), 0);
        req = '0;
        step();
        chk("basic_data", 64'(regData), 3);
        chk("basic_valid1", 64'(valid), 1);
        ack = 1'b1;
        step();
        chk("basic_done_valid", 64'(valid), 0);
        chk("basic_done_busy", 64'(busy), 0);
        ack = 1'b0;
        step();

        // Held response: q3 changes during RESP must not leak through
        req = 4'b0100; rd_sel = 8'b00_10_00_00;
        step();
        chk("hold_gnt0", 64'(gnt), 64'h4);
        req = '0;
        step();
        chk("hold_data0", 64'(regData), 3);
        q3 = 99;
        repeat (5) begin
            step();
            chk("hold_data", 64'(regData), 3);
            chk("hold_valid", 64'(valid), 1);
            chk("hold_gnt", 64'(gnt), 64'h4);
        end
        ack = 1'b1;
        step();
        chk("hold_done", 64'(valid), 0);
        ack = 1'b0; q3 = 3;
        step();

        // Reset in RESP aborts; requester 2 still asking is regranted
        req = 4'b0100;
        step(); step(); step();
        reset = 1'b1;
        step();
        chk("abort_gnt", 64'(gnt), 0);
        chk("abort_valid", 64'(valid), 0);
        chk("abort_data", 64'(regData), 0);
        chk("abort_busy", 64'(busy), 0);
        reset = 1'b0;
        step();
        chk("regrant_gnt", 64'(gnt), 64'h4);
        req = '0;
        step();
        chk("regrant_data", 64'(regData), 3);
        ack = 1'b1; step(); ack = 1'b0; step();

        // Requester 1 drops req right after grant; read of q2 still completes
        req = 4'b0010; rd_sel = 8'b00_00_01_00;
        step();
        chk("drop_gnt", 64'(gnt), 64'h2);
        req = '0;
        step();
        chk("drop_valid", 64'(valid), 1);
        chk("drop_data", 64'(regData), 2);
        ack = 1'b1; step(); ack = 1'b0; step();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            req    = 4'($urandom);
            rd_sel = 8'($urandom);
            q1 = $urandom; q2 = $urandom; q3 = $urandom; q4 = $urandom;
            ack    = ($urandom_range(1) == 1);
            reset  = ($urandom_range(39) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
